// File: rtl/winograd_tile_sequencer.sv
// rtl/winograd_tile_sequencer.sv - captures a grid of tiles and issues them one per handshake
//
// Sits between the combinational tile splitter and the back-pressured
// Winograd input-transform stage. A start strobe in IDLE snapshots the whole
// tile grid. The tiles are then presented in raster order, one per
// valid/ready handshake. The last tile of the image is flagged.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        capture tiles_in and begin sequencing (IDLE only)
//   clear        synchronous abort back to IDLE
//   tiles_in     full [row][col][i][j] tile grid from the splitter
//   tile_valid   tile_data/tile_row/tile_col/tile_last are valid
//   tile_ready   consumer accepts the current tile
//   tile_data    current tile, [i][j] elements
//   tile_row     grid row of current tile (zero-extended)
//   tile_col     grid column of current tile (zero-extended)
//   tile_last    current tile is the bottom-right tile of the grid
//   busy         sequencing in progress
//   done         one-cycle pulse after the final handshake
module winograd_tile_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_ROWS  = 3,
  parameter int TILE_COLS  = 3,
  parameter int TILE_SIZE  = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic [TILE_ROWS-1:0][TILE_COLS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] tiles_in,
  output logic tile_valid,
  input  logic tile_ready,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_data,
  output logic [1:0] tile_row,
  output logic [1:0] tile_col,
  output logic tile_last,
  output logic busy,
  output logic done
);

  localparam int RW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  localparam int CW = (TILE_COLS > 1) ? $clog2(TILE_COLS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(TILE_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(TILE_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [TILE_ROWS-1:0][TILE_COLS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] buffer;

  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic          last_nxt;

  // Raster-order successor of the current tile position.
  always_comb begin
    row_nxt = row;
    col_nxt = col + 1'b1;
    if (col == LAST_COL) begin
      col_nxt = '0;
      row_nxt = row + 1'b1;
    end
    last_nxt = (row_nxt == LAST_ROW) && (col_nxt == LAST_COL);
  end

  // The data mux reads only the capture buffer and the registered counters.
  // It therefore holds steady through a stall, and it is zero out of reset.
  assign tile_data = buffer[row][col];
  assign tile_row  = 2'(row);
  assign tile_col  = 2'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      buffer     <= '0;
      tile_valid <= 1'b0;
      tile_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      // Abort wins over start and over a coincident handshake.
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      tile_valid <= 1'b0;
      tile_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            buffer     <= tiles_in;
            row        <= '0;
            col        <= '0;
            state      <= S_SEND;
            tile_valid <= 1'b1;
            busy       <= 1'b1;
            tile_last  <= (TILE_ROWS == 1) && (TILE_COLS == 1);
          end
        end
        S_SEND: begin
          if (tile_ready) begin
            if (tile_last) begin
              state      <= S_DONE;
              row        <= '0;
              col        <= '0;
              tile_valid <= 1'b0;
              tile_last  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              row       <= row_nxt;
              col       <= col_nxt;
              tile_last <= last_nxt;
            end
          end
        end
        S_DONE: begin
          // A start seen here is dropped. The next one is honoured from IDLE.
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          tile_valid <= 1'b0;
          tile_last  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_tile_sequencer.sv
// tb/tb_winograd_tile_sequencer.sv - randomized self-checking bench for winograd_tile_sequencer
module tb_winograd_tile_sequencer;

  localparam int DW = 16;
  localparam int TR = 3;
  localparam int TC = 3;
  localparam int TS = 6;
  localparam int NT = TR * TC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic tile_ready = 1'b0;
  logic [TR-1:0][TC-1:0][TS-1:0][TS-1:0][DW-1:0] tiles_in;
  logic [TR-1:0][TC-1:0][TS-1:0][TS-1:0][DW-1:0] ref_buf;
  logic tile_valid, tile_last, busy, done;
  logic [TS-1:0][TS-1:0][DW-1:0] tile_data;
  logic [1:0] tile_row, tile_col;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  winograd_tile_sequencer #(
    .DATA_WIDTH(DW), .TILE_ROWS(TR), .TILE_COLS(TC), .TILE_SIZE(TS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .tiles_in(tiles_in), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .tile_row(tile_row), .tile_col(tile_col),
    .tile_last(tile_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: r*1000+c*100+i*6+j, mode 1: random, otherwise all ones
  task automatic fill(input int mode);
    for (int r = 0; r < TR; r++)
      for (int c = 0; c < TC; c++)
        for (int i = 0; i < TS; i++)
          for (int j = 0; j < TS; j++)
            case (mode)
              0:       tiles_in[r][c][i][j] = DW'(r * 1000 + c * 100 + i * 6 + j);
              1:       tiles_in[r][c][i][j] = DW'($urandom);
              default: tiles_in[r][c][i][j] = '1;
            endcase
  endtask

  // Issue start in IDLE. The model snapshots the grid at the same edge.
  task automatic start_seq();
    @(negedge clk);
    ref_buf = tiles_in;
    start = 1'b1;
    @(posedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(tile_valid), 64'(0));
    check({tag, "_busy"},  64'(busy),       64'(0));
    check({tag, "_done"},  64'(done),       64'(0));
  endtask

  // Present/accept n tiles. The expected tile is always the k-th raster
  // position of the snapshot. A stalled cycle must therefore show the same tile.
  task automatic run_tiles(input int n, input int rmode, input bit disturb,
                           input bit hold_start, input bit pat_check);
    int k;
    int cyc;
    bit rdy;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 300) begin
      @(negedge clk);
      start = hold_start;
      if (disturb) begin
        fill(2);
        start = 1'($urandom_range(0, 1));
      end
      check("valid", 64'(tile_valid), 64'(1));
      check("busy",  64'(busy),       64'(1));
      check("done_early", 64'(done),  64'(0));
      check("row",   64'(tile_row),   64'(k / TC));
      check("col",   64'(tile_col),   64'(k % TC));
      check("last",  64'(tile_last),  64'(k == NT - 1));
      check("data",  64'(tile_data === ref_buf[k / TC][k % TC]), 64'(1));
      if (pat_check && k == 4) check("elem55_tile5", 64'(tile_data[5][5]), 64'(1135));
      rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tile_ready = rdy;
      @(posedge clk);
      if (rdy) k++;
      cyc++;
    end
    if (k < n) check("timeout_tiles", 64'(k), 64'(n));
    if (n == NT) begin
      @(negedge clk);
      start = hold_start;
      check("done_pulse", 64'(done),       64'(1));
      check("done_busy",  64'(busy),       64'(0));
      check("done_valid", 64'(tile_valid), 64'(0));
      check("done_last",  64'(tile_last),  64'(0));
    end
  endtask

  initial begin
    fill(0);
    #12;
    check("rst_valid", 64'(tile_valid), 64'(0));
    check("rst_busy",  64'(busy),       64'(0));
    check("rst_done",  64'(done),       64'(0));
    check("rst_last",  64'(tile_last),  64'(0));
    check("rst_row",   64'(tile_row),   64'(0));
    check("rst_col",   64'(tile_col),   64'(0));
    check("rst_data",  64'(tile_data == '0), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // basic sequencing with fixed pattern, ready held high
    start_seq();
    run_tiles(NT, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("basic_end");

    // back-pressure with random data and random ready
    for (int rep = 0; rep < 3; rep++) begin
      fill(1);
      start_seq();
      run_tiles(NT, 1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_idle("bp_end");
    end

    // capture isolation: input overwritten and start re-pulsed during SEND
    fill(0);
    start_seq();
    run_tiles(NT, 1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check_idle("iso_end");

    // abort on tile (1,1) with a coincident handshake
    fill(1);
    start_seq();
    run_tiles(4, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_row", 64'(tile_row), 64'(1));
    check("abort_col", 64'(tile_col), 64'(1));
    clear = 1'b1;
    tile_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check_idle("abort");
    @(negedge clk);
    check_idle("abort_next");
    fill(1);
    start_seq();
    run_tiles(NT, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("abort_restart_end");

    // asynchronous reset between edges on tile (0,2)
    fill(1);
    start_seq();
    run_tiles(2, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_arst_col", 64'(tile_col), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(tile_valid), 64'(0));
    check("arst_busy",  64'(busy),       64'(0));
    check("arst_done",  64'(done),       64'(0));
    check("arst_last",  64'(tile_last),  64'(0));
    check("arst_row",   64'(tile_row),   64'(0));
    check("arst_col",   64'(tile_col),   64'(0));
    check("arst_data",  64'(tile_data == '0), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("arst_release");
    fill(0);
    start_seq();
    run_tiles(NT, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("arst_restart_end");

    // start held high: DONE then IDLE separate the two sequences
    fill(1);
    start_seq();
    run_tiles(NT, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("gap_idle");
    ref_buf = tiles_in;
    @(posedge clk);
    run_tiles(NT, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check_idle("gap2_idle");
    @(negedge clk);
    check_idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/winograd_tile_sequencer.md
Name: winograd_tile_sequencer

Overview:
- Downstream of the 10x12 -> 3x3 grid of 6x6 tile splitter.
- Captures the full 3x3x6x6 tile array on a start strobe, then issues the nine tiles one per valid/ready handshake, in raster order, to the Winograd input-transform stage (B^T d B).
- Decouples the combinational splitter from a back-pressured transform pipeline and flags the last tile of each image.

Parameters:
DATA_WIDTH, 16, bit width of each pixel element
TILE_ROWS, 3, tile rows in the grid
TILE_COLS, 3, tile columns in the grid
TILE_SIZE, 6, tile edge length in elements

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  capture tiles_in and begin sequencing; honoured only in IDLE
clear  input  1  synchronous abort; returns to IDLE from any state
tiles_in  input  DATA_WIDTH x [TILE_ROWS][TILE_COLS][TILE_SIZE][TILE_SIZE]  tile array from splitter
tile_valid  output  1  tile_data/tile_row/tile_col/tile_last are valid
tile_ready  input  1  consumer accepts the current tile
tile_data  output  DATA_WIDTH x [TILE_SIZE][TILE_SIZE]  current tile
tile_row  output  2  grid row index of current tile
tile_col  output  2  grid column index of current tile
tile_last  output  1  current tile is (TILE_ROWS-1, TILE_COLS-1)
busy  output  1  high from the cycle after an accepted start until done
done  output  1  single-cycle pulse after the final handshake

Behaviour:
- Reset (rst_n=0, asynchronous) forces the following, regardless of state:
  - state=IDLE; row/col counters=0; capture buffer=0.
  - tile_valid=0, busy=0, done=0, tile_last=0; tile_row/tile_col=0; tile_data=0.
- Reset asserted mid-sequence discards the in-flight image; no done pulse.
- States: IDLE, SEND, DONE.
- IDLE:
  - tile_valid=0.
  - On start=1 (and clear=0): latch all of tiles_in into the capture buffer, clear the counters, go to SEND.
  - Latency: start sampled at edge N -> tile_valid=1 from N+1.
- SEND:
  - tile_valid=1; tile_data=buffer[row][col]; tile_row=row, tile_col=col; tile_last=(row==TILE_ROWS-1 && col==TILE_COLS-1).
  - All outputs are driven from registers/buffer only and stay stable while tile_valid && !tile_ready.
  - Handshake = tile_valid && tile_ready at a rising edge.
  - On handshake, col increments; at col==TILE_COLS-1, col wraps to 0 and row increments.
  - Handshake while tile_last=1: go to DONE; tile_valid=0 next cycle.
  - Back-to-back handshakes are allowed: nine tiles in nine cycles minimum.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, next state IDLE.
- start is ignored in SEND and DONE; the buffer is not re-captured. tiles_in may change freely after capture.
- A start arriving in the DONE cycle is ignored. Earliest re-start is sampled in the following IDLE cycle.
- clear=1 at any edge:
  - next state IDLE, counters=0, tile_valid=0, no done pulse.
  - clear takes priority over start and over a simultaneous handshake (that handshake is not counted).
- busy=1 in SEND only.
- tile_ready is don't-care when tile_valid=0.
- The sequencer does no arithmetic; data passes bit-exact. Zero-padded elements from the splitter pass through unchanged.
- Counters are sized ceil(log2(TILE_ROWS)) / ceil(log2(TILE_COLS)) bits. tile_row/tile_col ports are zero-extended to 2 bits for the default parameters.

Test Plan:
- Basic sequencing:
  - Stimulus: tiles_in[r][c][i][j]=r*1000+c*100+i*6+j; start pulse; tile_ready held 1.
  - Required: tile_valid rises 1 cycle after start, then 9 consecutive handshakes.
  - Order (row,col)=(0,0),(0,1),...,(2,2); tile_data[5][5] of the 5th tile = 1135.
  - tile_last only on the 9th tile; done pulses the cycle after it, busy low from then.
- Back-pressure:
  - Stimulus: tile_ready toggles 1,0,0,1,... pseudo-randomly.
  - Required: tile_data/tile_row/tile_col held stable while stalled; exactly 9 tiles accepted, no duplicates or skips; done once.
- Capture isolation:
  - Stimulus: after start, drive tiles_in to all 16'hFFFF and pulse start again during SEND.
  - Required: emitted data still matches the original pattern; second start ignored; still 9 tiles.
- Abort:
  - Stimulus: clear asserted with tile_ready=1 while presenting tile (1,1).
  - Required: next cycle tile_valid=0, busy=0, no done.
  - A following start restarts at (0,0) with newly captured data.
- Async reset mid-operation:
  - Stimulus: drop rst_n between clock edges while on tile (0,2).
  - Required: all outputs 0 immediately, before the next edge. After release, start produces a full 9-tile sequence from (0,0).
- Restart timing:
  - Stimulus: start held high continuously.
  - Required: start in the DONE cycle ignored; a new sequence begins from the following IDLE cycle. Two complete 9-tile sequences are separated by exactly two cycles of tile_valid=0 (DONE, IDLE).
